// File: rtl/action_input_ctrl_if.sv
// Button, pause and command bundle between the player input front end and the runner movement stage.
// The master side drives the keys and pause; the slave side (action_input_ctrl) returns the frame tick and move command.
interface action_input_ctrl_if;
  logic       key_big;
  logic       key_small;
  logic       key_drop;
  logic       pause;
  logic       update;
  logic [2:0] operation;
  logic       busy;
  logic [3:0] ticks_left;

  modport master (
    output key_big, key_small, key_drop, pause,
    input  update, operation, busy, ticks_left
  );

  modport slave (
    input  key_big, key_small, key_drop, pause,
    output update, operation, busy, ticks_left
  );
endinterface

// File: rtl/action_input_ctrl.sv
// Debounces the three runner buttons, generates the frame update tick and issues one
// one-hot move command per accepted press, locking out further presses until the move ends.
module action_input_ctrl #(
  parameter int UPDATE_DIV      = 833333,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BIG_TICKS       = 10,
  parameter int SMALL_TICKS     = 15,
  parameter int DROP_TICKS      = 9
) (
  input  logic                clk,
  input  logic                reset,
  action_input_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(UPDATE_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] BIG_T   = 4'(BIG_TICKS);
  localparam logic [3:0] SMALL_T = 4'(SMALL_TICKS);
  localparam logic [3:0] DROP_T  = 4'(DROP_TICKS);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  // Bit order matches the one-hot command encoding: 0 big, 1 small, 2 drop.
  logic [2:0] key_raw;
  assign key_raw = {bus.key_drop, bus.key_small, bus.key_big};

  logic [2:0]      key_p0;
  logic [2:0]      key_p1;
  logic [2:0]      level_p2;
  logic [2:0]      press_p2;
  logic [DB_W-1:0] db_cnt [3];

  // p0/p1: two-flop synchroniser; p2: debounced level and its rising-edge press pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_p0   <= '0;
      key_p1   <= '0;
      level_p2 <= '0;
      press_p2 <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
      for (int i = 0; i < 3; i++) begin
        press_p2[i] <= 1'b0;
        if (key_p1[i] == level_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          level_p2[i] <= key_p1[i];
          press_p2[i] <= key_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic             update_r;

  // Frame divider: pause holds the count so the frame phase resumes where it stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      update_r <= 1'b0;
    end else if (bus.pause) begin
      update_r <= 1'b0;
    end else begin
      update_r <= (div_cnt == DIV_LAST);
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  state_t     state, state_n;
  logic [2:0] op_r, op_n;
  logic [3:0] ticks_r, ticks_n;
  logic       fresh, fresh_n;
  logic [3:0] move_ticks;

  always_comb begin
    case (op_r)
      3'b001:  move_ticks = BIG_T;
      3'b010:  move_ticks = SMALL_T;
      default: move_ticks = DROP_T;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_r    <= '0;
      ticks_r <= '0;
      fresh   <= 1'b0;
    end else begin
      state   <= state_n;
      op_r    <= op_n;
      ticks_r <= ticks_n;
      fresh   <= fresh_n;
    end
  end

  // fresh marks the ISSUE entry cycle, whose update pulse must not end the issue phase.
  always_comb begin
    state_n = state;
    op_n    = op_r;
    ticks_n = ticks_r;
    fresh_n = 1'b0;
    case (state)
      IDLE: begin
        if (|press_p2) begin
          state_n = ISSUE;
          fresh_n = 1'b1;
          if (press_p2[0])      op_n = 3'b001;
          else if (press_p2[1]) op_n = 3'b010;
          else                  op_n = 3'b100;
        end
      end
      ISSUE: begin
        if (update_r && !fresh) begin
          op_n = '0;
          if (move_ticks == 4'd1) begin
            state_n = IDLE;
            ticks_n = '0;
          end else begin
            state_n = HOLD;
            ticks_n = move_ticks - 4'd1;
          end
        end
      end
      HOLD: begin
        if (update_r) begin
          if (ticks_r <= 4'd1) begin
            state_n = IDLE;
            ticks_n = '0;
          end else begin
            ticks_n = ticks_r - 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        op_n    = '0;
        ticks_n = '0;
      end
    endcase
  end

  assign bus.update     = update_r;
  assign bus.operation  = op_r;
  assign bus.busy       = (state != IDLE);
  assign bus.ticks_left = ticks_r;

endmodule

// File: tb/tb_action_input_ctrl.sv
// Scoreboard bench for action_input_ctrl: each accepted press pushes its expected command,
// issue cycle and tick count; a negedge monitor pops and checks them as commands appear.
module tb_action_input_ctrl;

  localparam int UPDATE_DIV = 4;
  localparam int DEB        = 3;
  localparam int LAT        = DEB + 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  logic paused_at_edge = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  action_input_ctrl_if bus ();

  action_input_ctrl #(
    .UPDATE_DIV      (UPDATE_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .BIG_TICKS       (10),
    .SMALL_TICKS     (15),
    .DROP_TICKS      (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc            <= cyc + 1;
    paused_at_edge <= bus.pause;
  end

  typedef struct packed {
    logic [2:0] op;
    int         cyc;
    int         ticks;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor state
  logic [2:0] prev_op   = '0;
  bit         in_hold   = 0;
  int         upd_cnt   = 0;
  int         cur_ticks = 0;
  int         last_upd  = -1;
  bit         pause_seen = 0;
  exp_t       e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_op    = '0;
      in_hold    = 0;
      upd_cnt    = 0;
      last_upd   = -1;
      pause_seen = 0;
    end else begin
      if (paused_at_edge) begin
        check_val("upd_paused", 32'(bus.update), 0);
        pause_seen = 1;
      end
      if (bus.update) begin
        if (last_upd >= 0 && !pause_seen) check_val("upd_period", cyc - last_upd, UPDATE_DIV);
        last_upd   = cyc;
        pause_seen = 0;
        if (in_hold) upd_cnt++;
      end
      if (prev_op == 3'b000 && bus.operation != 3'b000) begin
        if (sb.size() == 0) begin
          check_val("unexpected_op", 32'(bus.operation), 0);
        end else begin
          e = sb.pop_front();
          check_val("op_value", 32'(bus.operation), 32'(e.op));
          check_val("op_cycle", cyc, e.cyc);
          cur_ticks = e.ticks;
        end
        check_val("busy_issue", 32'(bus.busy), 1);
      end
      if (prev_op != 3'b000 && bus.operation == 3'b000) begin
        check_val("ticks_load", 32'(bus.ticks_left), cur_ticks - 1);
        in_hold = 1;
        upd_cnt = 1;
      end
      if (in_hold && !bus.busy) begin
        check_val("upd_count", upd_cnt, cur_ticks);
        check_val("ticks_idle", 32'(bus.ticks_left), 0);
        in_hold = 0;
      end
      prev_op = bus.operation;
    end
  end

  task automatic expect_cmd(input logic [2:0] op, input int ticks);
    exp_t x;
    x.op    = op;
    x.cyc   = cyc + LAT;
    x.ticks = ticks;
    sb.push_back(x);
  endtask

  task automatic wait_op(input int limit);
    int n = 0;
    while (bus.operation == 3'b000 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.operation == 3'b000) check_val("timeout_op", 0, 1);
  endtask

  task automatic wait_clear(input int limit);
    int n = 0;
    while (bus.operation != 3'b000 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.operation != 3'b000) check_val("timeout_clear", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check_val("timeout_idle", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_op"},     32'(bus.operation),  0);
    check_val({tag, "_busy"},   32'(bus.busy),       0);
    check_val({tag, "_ticks"},  32'(bus.ticks_left), 0);
    check_val({tag, "_update"}, 32'(bus.update),     0);
  endtask

  initial begin
    int t_frozen;
    reset         = 1'b0;
    bus.key_big   = 1'b0;
    bus.key_small = 1'b0;
    bus.key_drop  = 1'b0;
    bus.pause     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Idle: update pulses only, no command
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        check_val("idle_busy",  32'(bus.busy),       0);
        check_val("idle_ticks", 32'(bus.ticks_left), 0);
      end
    end

    // Big jump, key held through the whole move
    bus.key_big = 1'b1;
    expect_cmd(3'b001, 10);
    wait_op(40);
    wait_idle(300);
    repeat (10) @(negedge clk);
    bus.key_big = 1'b0;
    repeat (12) @(negedge clk);

    // Small and drop together: small wins
    bus.key_small = 1'b1;
    bus.key_drop  = 1'b1;
    expect_cmd(3'b010, 15);
    repeat (8) @(negedge clk);
    bus.key_small = 1'b0;
    bus.key_drop  = 1'b0;
    wait_op(40);
    wait_idle(300);
    repeat (12) @(negedge clk);

    // Drop glitch shorter than the debounce window
    bus.key_drop = 1'b1;
    repeat (2) @(negedge clk);
    bus.key_drop = 1'b0;
    repeat (15) @(negedge clk);
    check_val("glitch_op", 32'(bus.operation), 0);
    check_val("glitch_busy", 32'(bus.busy), 0);

    // Drop pulse of exactly the debounce length
    bus.key_drop = 1'b1;
    expect_cmd(3'b100, 9);
    repeat (3) @(negedge clk);
    bus.key_drop = 1'b0;
    wait_op(40);
    wait_idle(300);
    repeat (12) @(negedge clk);

    // Big press during a small jump's hold phase is discarded
    bus.key_small = 1'b1;
    expect_cmd(3'b010, 15);
    wait_op(40);
    bus.key_small = 1'b0;
    wait_clear(100);
    repeat (4) @(negedge clk);
    bus.key_big = 1'b1;
    repeat (8) @(negedge clk);
    check_val("lockout_busy", 32'(bus.busy), 1);
    bus.key_big = 1'b0;
    wait_idle(300);
    repeat (20) @(negedge clk);
    check_val("lockout_sb", sb.size(), 0);
    check_val("lockout_op", 32'(bus.operation), 0);

    // Pause during hold freezes the countdown
    bus.key_drop = 1'b1;
    expect_cmd(3'b100, 9);
    wait_op(40);
    bus.key_drop = 1'b0;
    wait_clear(100);
    repeat (3) @(negedge clk);
    bus.pause = 1'b1;
    repeat (2) @(negedge clk);
    t_frozen = int'(bus.ticks_left);
    repeat (18) @(negedge clk);
    check_val("pause_ticks", 32'(bus.ticks_left), t_frozen);
    check_val("pause_busy",  32'(bus.busy), 1);
    bus.pause = 1'b0;
    wait_idle(300);
    repeat (12) @(negedge clk);

    // Reset mid-hold, key held across reset
    bus.key_big = 1'b1;
    expect_cmd(3'b001, 10);
    wait_op(40);
    wait_clear(100);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check_reset_outputs("inrst");
    reset = 1'b1;
    expect_cmd(3'b001, 10);
    wait_op(40);
    wait_idle(300);
    bus.key_big = 1'b0;
    repeat (12) @(negedge clk);

    check_val("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/action_input_ctrl.md
Name: action_input_ctrl

Overview:
Upstream stage of the runner movement block. It filters the three raw player buttons (big jump, small jump, drop) and generates the periodic frame `update` tick. It issues exactly one one-hot `operation` command per accepted press. While a move is in progress, further presses are locked out, so the movement stage never receives overlapping commands.

Parameters:
- UPDATE_DIV, 833333, clk cycles per update tick (60 Hz at 50 MHz); must be ≥2.
- DEBOUNCE_CYCLES, 500000, consecutive identical synchronised samples needed to accept a new key level; must be ≥1.
- BIG_TICKS, 10, update ticks a big jump occupies; range 1..15.
- SMALL_TICKS, 15, update ticks a small jump occupies; range 1..15.
- DROP_TICKS, 9, update ticks a drop occupies; range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_big  in  1  raw big-jump button, active-high, asynchronous to clk
- key_small  in  1  raw small-jump button, active-high, asynchronous
- key_drop  in  1  raw drop button, active-high, asynchronous
- pause  in  1  synchronous; 1 freezes the update divider
- update  out  1  one-clk pulse per frame tick
- operation  out  3  one-hot command: 001 big jump, 010 small jump, 100 drop, 000 none
- busy  out  1  1 while in ISSUE or HOLD
- ticks_left  out  4  remaining update ticks of the current move

Behaviour:
- Reset (reset=0, asynchronous) forces the following, all held until reset releases:
  - state=IDLE;
  - divider count=0;
  - update=0, operation=000, busy=0, ticks_left=0;
  - synchroniser flops=0, debounce counters=0, debounced levels=0.
- Per key input path:
  - 2-flop synchroniser feeds a debounce filter.
  - The filter counts cycles in which the synchronised sample differs from the debounced level.
  - The count resets to 0 on any cycle where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the count clears.
  - A press event is a one-cycle pulse on a 0→1 transition of the debounced level. Releases generate nothing.
- Raw-to-press latency is DEBOUNCE_CYCLES+2 clk cycles.
  - A raw pulse shorter than DEBOUNCE_CYCLES cycles produces no event.
  - A key held through reset release produces a press after DEBOUNCE_CYCLES+2 cycles.
- Update divider:
  - Counts 0..UPDATE_DIV-1 and wraps to 0.
  - `update` is registered and is 1 for the single cycle after the count equals UPDATE_DIV-1.
  - While pause=1 the count holds and `update` is 0. Counting resumes from the held value.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: on any press event, latch the command and go to ISSUE next cycle.
    - Simultaneous presses resolve by priority: big > small > drop.
    - No press: stay in IDLE.
  - ISSUE: `operation` holds the latched one-hot command (registered; first 1 in the cycle ISSUE is entered, raw-to-operation DEBOUNCE_CYCLES+3 cycles).
    - Stays in ISSUE until the first `update` pulse that occurs after entry; an update in the entry cycle itself does not count.
    - On that pulse: operation←000, ticks_left←the command's *_TICKS minus 1, go to HOLD.
    - If *_TICKS=1, go straight to IDLE instead.
  - HOLD: each `update` pulse decrements ticks_left.
    - When an update arrives with ticks_left=1: ticks_left←0, go to IDLE.
  - busy=1 in ISSUE and HOLD, 0 in IDLE.
- Lockout: press events occurring in ISSUE or HOLD are discarded, not queued. A press in the same cycle as the HOLD→IDLE transition is also discarded.
- pause=1 freezes ISSUE/HOLD progress implicitly, because no update pulses arrive. Press acceptance in IDLE is unaffected by pause.
- Reset mid-move: immediate return to IDLE with operation=000, no further command emitted.
- ticks_left never underflows; it is 0 in IDLE.

Test Plan (UPDATE_DIV=4, DEBOUNCE_CYCLES=3, BIG_TICKS=10, SMALL_TICKS=15, DROP_TICKS=9 unless stated):
- Reset release, no keys → update pulses every 4 cycles; operation=000, busy=0, ticks_left=0 throughout.
- key_big raised at cycle 0 and held → operation=001 first at cycle 6.
  - operation clears at the next update pulse, when ticks_left=9.
  - busy falls after the 10th update counted from the issue pulse.
- key_small and key_drop raised in the same cycle → operation=010 only; ticks_left loads 14.
- key_drop glitch 2 cycles high → no operation. A 3-cycle-plus pulse → operation=100, ticks_left loads 8.
- key_big pressed during HOLD of a small jump → ignored; operation stays 000 until IDLE, and no command follows.
- reset pulsed low during HOLD → outputs return to reset values within the reset cycle. A key held across reset → new command at DEBOUNCE_CYCLES+3 cycles after release.
- pause=1 for 20 cycles during HOLD → no update pulses and ticks_left frozen; countdown resumes after pause=0.
